// File: rtl/flux_demux_if.sv
// Handshake bundle between the shared tagged-word FIFO and the per-flux output FIFOs.
// The master side is the demux; the slave side is the FIFO environment.
interface flux_demux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

  logic [WIDTH-1:0]           in_dout;
  logic                       in_empty;
  logic                       in_read;
  logic [FLUX*DATA_WIDTH-1:0] out_din;
  logic [FLUX-1:0]            out_write;
  logic [FLUX-1:0]            out_full;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_read, out_din, out_write
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_read, out_din, out_write
  );
endinterface

// File: rtl/flux_demux.sv
// Routes tagged words from one shared FIFO to per-flux FIFOs through a single
// registered stage, counting delivered tokens per flux and dropped bad-tag words.
module flux_demux #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  flux_demux_if.master              bus,
  output logic [FLUX*CNT_WIDTH-1:0] tok_cnt,
  output logic [CNT_WIDTH-1:0]      drop_cnt,
  output logic                      err_tag
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

  logic                  stg_vld;
  logic [TAG_WIDTH-1:0]  stg_tag;
  logic [DATA_WIDTH-1:0] stg_data;
  logic [CNT_WIDTH-1:0]  cnt [FLUX];

  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  tag_ok;
  logic                  full_sel;
  logic                  drain;
  logic                  pop;

  assign in_tag  = bus.in_dout[WIDTH-1:DATA_WIDTH];
  assign in_data = bus.in_dout[DATA_WIDTH-1:0];

  // Out-of-range tags only exist when FLUX leaves unused tag codes.
  if ((1 << TAG_WIDTH) == FLUX) begin : g_pow2
    assign tag_ok = 1'b1;
  end else begin : g_npow2
    assign tag_ok = (in_tag < TAG_WIDTH'(FLUX));
  end

  always_comb begin
    full_sel = 1'b0;
    for (int f = 0; f < FLUX; f++) begin
      if (stg_tag == TAG_WIDTH'(f)) full_sel = bus.out_full[f];
    end
  end

  // Gating with rst keeps a held word from leaking out during the reset cycle.
  assign drain       = rst & stg_vld & ~full_sel;
  assign pop         = rst & ~bus.in_empty & (~stg_vld | drain);
  assign bus.in_read = pop;

  always_comb begin
    bus.out_write = '0;
    bus.out_din   = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (stg_tag == TAG_WIDTH'(f)) begin
        bus.out_write[f]                           = drain;
        bus.out_din[f*DATA_WIDTH +: DATA_WIDTH]    = stg_data;
      end
    end
  end

  for (genvar g = 0; g < FLUX; g++) begin : g_cnt_out
    assign tok_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_vld  <= 1'b0;
      stg_tag  <= '0;
      stg_data <= '0;
      drop_cnt <= '0;
      err_tag  <= 1'b0;
      for (int f = 0; f < FLUX; f++) cnt[f] <= '0;
    end else begin
      err_tag <= pop & ~tag_ok;
      if (pop & tag_ok) begin
        stg_vld  <= 1'b1;
        stg_tag  <= in_tag;
        stg_data <= in_data;
      end else if (drain) begin
        stg_vld  <= 1'b0;
      end
      if (pop & ~tag_ok) drop_cnt <= drop_cnt + 1'b1;
      for (int f = 0; f < FLUX; f++) begin
        if (bus.out_write[f]) cnt[f] <= cnt[f] + 1'b1;
      end
    end
  end
endmodule
